uio_bus_arbiter: RTL and testbench
==================================

Name: uio_bus_arbiter

Overview:
- Time-shares the bidirectional uio pin bank between two requesters.
- The OUT requester (e.g. the free-running counter) drives the pins; the IN requester samples externally driven pins.
- Guarantees a dead (oe=0) turnaround window between ownership changes, so on-chip and off-chip drivers never fight.
- Contains its own reset synchroniser and sits between the user datapath and the uio_in/uio_out/uio_oe top-level pins.

Parameters:
WIDTH, 8, width of the uio bank and data paths
TURN_CYCLES, 2, dead cycles (uio_oe=0) inserted after every grant ends; legal 1..15
MAX_HOLD, 16, max consecutive grant cycles while the other requester waits; legal 2..255

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_out  in  1  OUT requester wants to drive pins; level, held until done
out_data  in  WIDTH  data to drive while OUT is granted
req_in  in  1  IN requester wants to sample pins; level
uio_in  in  WIDTH  pin input path
uio_out  out  WIDTH  pin output path
uio_oe  out  WIDTH  pin output enable, all-ones or all-zeros only
gnt_out  out  1  OUT requester currently owns the pins
gnt_in  out  1  IN requester currently owns the pins
in_data  out  WIDTH  last sampled pin value
in_valid  out  1  in_data updated this cycle
busy  out  1  state != IDLE

Behaviour:
- Reset: rst_n is already decided as asynchronous, active-low; clk is the clock.
  - rst_n low immediately forces state=IDLE, uio_oe=0, uio_out=0, gnt_out=0, gnt_in=0, in_data=0, in_valid=0, hold_cnt=0, turn_cnt=0, last=IN.
  - Deassertion passes through a 2-flop synchroniser: the FSM leaves reset 2 clk edges after rst_n rises.
- All outputs are registered. uio_oe equals {WIDTH{gnt_out}} on every cycle.
- States: IDLE, DRIVE, SAMPLE, TURN.
- IDLE (oe=0):
  - req_out only -> DRIVE.
  - req_in only -> SAMPLE.
  - Both asserted -> grant the side not equal to last. last resets to IN, so OUT wins the first tie.
  - Neither -> stay in IDLE.
  - A transition sets gnt_* on the next cycle, so grant latency is 1 cycle from request.
- DRIVE:
  - gnt_out=1, uio_oe=all-ones.
  - Each edge in DRIVE (including the entry edge) captures uio_out <= out_data, so uio_out lags out_data by 1 cycle.
  - hold_cnt increments every cycle.
  - Exit to TURN when req_out=0, or when hold_cnt==MAX_HOLD-1 with req_in=1.
  - On exit: last<=OUT, gnt_out=0, uio_oe=0, uio_out=0 on the first TURN cycle.
- SAMPLE:
  - gnt_in=1, oe=0.
  - Each edge in SAMPLE captures in_data <= uio_in and sets in_valid=1 for that cycle. in_valid=0 in every other state.
  - Same exit rule as DRIVE with the roles swapped; on exit, last<=IN.
- TURN:
  - oe=0, no grants, turn_cnt counts TURN_CYCLES cycles, then -> IDLE.
  - Requests seen during TURN are only evaluated in IDLE.
  - Exactly TURN_CYCLES+1 cycles separate the last grant cycle from the next grant cycle.
- hold_cnt and turn_cnt clear on every state entry.
- hold_cnt saturates at MAX_HOLD-1 when there is no contender, so a lone requester holds the pins indefinitely.
- Dropping a request mid-grant always takes TURN; there is no direct DRIVE<->SAMPLE path.
- Both requests dropping in the same cycle -> TURN -> IDLE.
- Requests are not validated: req_out rising while in SAMPLE is simply pending.

Test Plan:
- Reset: rst_n=0 mid-DRIVE -> uio_oe=00, gnt_out=0 combinationally; rst_n rises -> no grant before the 3rd clk edge even with req_out=1.
- Single OUT: req_out=1 with out_data=0x5A at cycle 0 -> gnt_out=1, uio_oe=FF at cycle 1, uio_out=5A at cycle 1; out_data=0x3C at cycle 3 -> uio_out=3C at cycle 4.
- Single IN: req_in=1, uio_in=0xA7 -> gnt_in=1 at cycle 1, in_valid=1 with in_data=A7 from cycle 1; uio_oe stays 00 throughout.
- Tie after reset: req_out=req_in=1 from IDLE -> OUT granted first; with MAX_HOLD=16, gnt_out holds 16 cycles, then 2 cycles of oe=0/no grant, then gnt_in=1.
- Fairness: both requests held 100 cycles -> grants strictly alternate OUT/IN, each lasting 16 cycles, separated by 2 dead cycles; uio_oe is never FF while gnt_in=1.
- Release: req_out drops in cycle 5 of DRIVE -> uio_oe=00 next cycle; a req_in raised in that same cycle is granted exactly 3 cycles after the last gnt_out cycle.

Source files
------------

// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter: time-shares the bidirectional uio pin bank between an
// OUT requester (drives the pins) and an IN requester (samples the pins).
// Every change of ownership passes through a dead window with the output
// enables off, so on-chip and off-chip drivers never fight.
module uio_bus_arbiter #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 2,   // 1..15
  parameter int MAX_HOLD    = 16   // 2..255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_out,
  input  logic [WIDTH-1:0] out_data,
  input  logic             req_in,
  input  logic [WIDTH-1:0] uio_in,
  output logic [WIDTH-1:0] uio_out,
  output logic [WIDTH-1:0] uio_oe,
  output logic             gnt_out,
  output logic             gnt_in,
  output logic [WIDTH-1:0] in_data,
  output logic             in_valid,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, TURN} state_t;
  typedef enum logic {SIDE_IN, SIDE_OUT} side_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  localparam logic [3:0] TURN_LAST = 4'(TURN_CYCLES - 1);

  logic [1:0]       rst_sync_q;
  logic             run;
  state_t           state_q, state_d;
  state_t           pick;
  side_t            last_q, last_d;
  logic [7:0]       hold_q, hold_d;
  logic [3:0]       turn_q, turn_d;

  logic [WIDTH-1:0] uio_out_q;
  logic [WIDTH-1:0] uio_oe_q;
  logic             gnt_out_q;
  logic             gnt_in_q;
  logic [WIDTH-1:0] in_data_q;
  logic             in_valid_q;
  logic             busy_q;

  // Reset synchroniser: assertion is immediate, release takes two edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign run = rst_sync_q[1];

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= SIDE_IN;
      hold_q  <= 8'd0;
      turn_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
    end
  end

  // Arbitration decision used whenever the bank is free: a tie goes to the
  // side that did not own the pins last.
  always_comb begin
    pick = IDLE;
    if (req_out && req_in) begin
      pick = (last_q == SIDE_OUT) ? SAMPLE : DRIVE;
    end else if (req_out) begin
      pick = DRIVE;
    end else if (req_in) begin
      pick = SAMPLE;
    end
  end

  // Next-state logic. The final TURN cycle hands over straight to the free-bank
  // decision so exactly TURN_CYCLES dead cycles sit between two grants.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    case (state_q)
      IDLE: begin
        state_d = pick;
      end
      DRIVE: begin
        if (!req_out || (hold_q == HOLD_LAST && req_in)) begin
          state_d = TURN;
          last_d  = SIDE_OUT;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 8'd1;
        end
      end
      SAMPLE: begin
        if (!req_in || (hold_q == HOLD_LAST && req_out)) begin
          state_d = TURN;
          last_d  = SIDE_IN;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 8'd1;
        end
      end
      TURN: begin
        if (turn_q == TURN_LAST) begin
          state_d = pick;
        end else begin
          turn_d = turn_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Counters restart on every state entry.
    if (state_d != state_q) begin
      hold_d = 8'd0;
      turn_d = 4'd0;
    end
    // Hold everything parked until the synchronised reset has released.
    if (!run) begin
      state_d = IDLE;
      last_d  = SIDE_IN;
      hold_d  = 8'd0;
      turn_d  = 4'd0;
    end
  end

  // Registered outputs, derived from the state being entered so a grant is
  // visible one cycle after the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uio_out_q  <= '0;
      uio_oe_q   <= '0;
      gnt_out_q  <= 1'b0;
      gnt_in_q   <= 1'b0;
      in_data_q  <= '0;
      in_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      uio_out_q  <= (state_d == DRIVE) ? out_data : '0;
      uio_oe_q   <= {WIDTH{state_d == DRIVE}};
      gnt_out_q  <= (state_d == DRIVE);
      gnt_in_q   <= (state_d == SAMPLE);
      in_valid_q <= (state_d == SAMPLE);
      busy_q     <= (state_d != IDLE);
      if (state_d == SAMPLE) begin
        in_data_q <= uio_in;
      end
    end
  end

  assign uio_out  = uio_out_q;
  assign uio_oe   = uio_oe_q;
  assign gnt_out  = gnt_out_q;
  assign gnt_in   = gnt_in_q;
  assign in_data  = in_data_q;
  assign in_valid = in_valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Testbench for uio_bus_arbiter: directed phases with random data and
// random request patterns, compared every cycle with a behavioural model.
module tb_uio_bus_arbiter;
  localparam int W  = 8;
  localparam int TC = 2;
  localparam int MH = 16;

  localparam int M_NONE = 0;
  localparam int M_OUT  = 1;
  localparam int M_IN   = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_out;
  logic [W-1:0] out_data;
  logic         req_in;
  logic [W-1:0] uio_in;
  logic [W-1:0] uio_out;
  logic [W-1:0] uio_oe;
  logic         gnt_out;
  logic         gnt_in;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         busy;

  int total = 0;
  int bad   = 0;

  // Model: who owns the bank, how many grant cycles it has had so far,
  // how many dead cycles remain, who owned it last, reset warm-up edges.
  int           m_owner;
  int           m_held;
  int           m_dead;
  int           m_last;
  int           m_warm;
  logic [W-1:0] m_uio_out;
  logic [W-1:0] m_in_data;

  always #5 clk = ~clk;

  uio_bus_arbiter #(
    .WIDTH(W),
    .TURN_CYCLES(TC),
    .MAX_HOLD(MH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_out(req_out),
    .out_data(out_data),
    .req_in(req_in),
    .uio_in(uio_in),
    .uio_out(uio_out),
    .uio_oe(uio_oe),
    .gnt_out(gnt_out),
    .gnt_in(gnt_in),
    .in_data(in_data),
    .in_valid(in_valid),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0t got=%h exp=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner   = M_NONE;
    m_held    = 0;
    m_dead    = 0;
    m_last    = M_IN;
    m_warm    = 2;
    m_uio_out = '0;
    m_in_data = '0;
  endtask

  // One clock edge of the arbitration rules, using the inputs present at it.
  task automatic model_edge();
    int winner;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_warm > 0) begin
      m_warm--;
      return;
    end
    if (m_owner == M_OUT) begin
      if (!req_out || (m_held >= MH && req_in)) begin
        m_owner = M_NONE;
        m_dead  = TC;
        m_last  = M_OUT;
      end else begin
        m_held++;
      end
    end else if (m_owner == M_IN) begin
      if (!req_in || (m_held >= MH && req_out)) begin
        m_owner = M_NONE;
        m_dead  = TC;
        m_last  = M_IN;
      end else begin
        m_held++;
      end
    end else if (m_dead > 1) begin
      m_dead--;
    end else begin
      m_dead = 0;
      winner = M_NONE;
      if (req_out && req_in) winner = (m_last == M_IN) ? M_OUT : M_IN;
      else if (req_out) winner = M_OUT;
      else if (req_in) winner = M_IN;
      if (winner != M_NONE) begin
        m_owner = winner;
        m_held  = 1;
      end
    end
    m_uio_out = (m_owner == M_OUT) ? out_data : '0;
    if (m_owner == M_IN) m_in_data = uio_in;
  endtask

  function automatic logic [63:0] exp_vec();
    logic [W-1:0] oe;
    oe = (m_owner == M_OUT) ? {W{1'b1}} : {W{1'b0}};
    return {36'b0, m_uio_out, oe, (m_owner == M_OUT), (m_owner == M_IN),
            m_in_data, (m_owner == M_IN), ((m_owner != M_NONE) || (m_dead > 0))};
  endfunction

  // Advance one clock, update the model, then compare just after the edge.
  task automatic cycle(input string tag);
    logic bad_oe;
    @(posedge clk);
    model_edge();
    #1;
    chk(tag, {36'b0, uio_out, uio_oe, gnt_out, gnt_in, in_data, in_valid, busy}, exp_vec());
    bad_oe = (uio_oe != '0 && uio_oe != {W{1'b1}}) || (gnt_in && uio_oe != '0);
    chk({tag, "_oe"}, 64'(bad_oe), 64'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    req_out  = 1'b0;
    req_in   = 1'b0;
    out_data = '0;
    uio_in   = '0;
    model_reset();
    repeat (3) cycle("reset");

    // Tie straight out of reset, held long enough to see several alternations.
    rst_n   = 1'b1;
    req_out = 1'b1;
    req_in  = 1'b1;
    repeat (100) begin
      out_data = W'($urandom);
      uio_in   = W'($urandom);
      cycle("tie");
    end
    req_out = 1'b0;
    req_in  = 1'b0;
    repeat (6) cycle("drop_both");

    // Single OUT with fixed data pattern, released in grant cycle 5
    // while IN raises its request in the same cycle.
    out_data = 8'h5A;
    req_out  = 1'b1;
    cycle("out_c1");
    cycle("out_c2");
    cycle("out_c3");
    out_data = 8'h3C;
    cycle("out_c4");
    cycle("out_c5");
    req_out = 1'b0;
    req_in  = 1'b1;
    uio_in  = 8'hA7;
    repeat (4) cycle("release");
    repeat (10) begin
      uio_in = W'($urandom);
      cycle("single_in");
    end
    req_in = 1'b0;
    repeat (5) cycle("idle");

    // Random request patterns.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) req_out = ~req_out;
      if ($urandom_range(0, 5) == 0) req_in = ~req_in;
      out_data = W'($urandom);
      uio_in   = W'($urandom);
      cycle("random");
    end

    // Reset in the middle of a DRIVE grant.
    req_out = 1'b1;
    req_in  = 1'b0;
    repeat (8) cycle("pre_rst");
    chk("in_drive", 64'(gnt_out), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_oe", 64'(uio_oe), 64'd0);
    chk("async_gnt", 64'(gnt_out), 64'd0);
    chk("async_uio_out", 64'(uio_out), 64'd0);
    model_reset();
    repeat (2) cycle("rst2");
    rst_n = 1'b1;
    repeat (8) begin
      out_data = W'($urandom);
      cycle("resync");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
